// File: rtl/bus_sequencer.sv
// 68000 bus-cycle controller: region decode, wait states,
// DTACK/BERR generation, CPU reset pulse and single-step gating.
module bus_sequencer #(
  parameter int NUM_CS = 4,
  parameter int ADDR_W = 24,
  parameter logic [NUM_CS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_CS*ADDR_W-1:0] REGION_MASK = '0,
  parameter logic [NUM_CS*4-1:0] REGION_WAIT = '0,
  parameter logic [NUM_CS-1:0] REGION_RO = '0,
  parameter int BERR_TIMEOUT = 64,
  parameter int RESET_CYCLES = 16
) (
  input  logic              CPUCLK_IN,
  input  logic              RESET_n,
  input  logic              AS_IN,
  input  logic              WR_IN,
  input  logic              UDS_IN,
  input  logic              LDS_IN,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic              EXTACK_IN,
  input  logic              STEPEN_IN,
  input  logic              STEP_IN,
  output logic              CPU_RESET,
  output logic              CPU_HALT,
  output logic              RUN,
  output logic              DTACK,
  output logic              BERR,
  output logic [NUM_CS-1:0] CSU,
  output logic [NUM_CS-1:0] CSL,
  output logic              OE,
  output logic              WE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_STEP,
    S_ACK,
    S_ERR
  } state_t;

  state_t state;

  logic [NUM_CS-1:0] hit;
  logic [NUM_CS-1:0] win;
  logic [NUM_CS-1:0] sel;
  logic [3:0] win_wait;
  logic [3:0] wcnt;
  logic win_ro;
  logic any_hit;
  logic ext;
  logic ack_now;
  logic rst_last;
  logic halt_clr;
  logic step_pulse;
  logic [7:0] wd;
  logic [7:0] wd_nxt;
  logic [7:0] rst_cnt;
  logic [2:0] step_sync;

  // Parallel region compare; the lowest hitting index wins
  always_comb begin
    hit = '0;
    win = '0;
    win_wait = '0;
    for (int i = 0; i < NUM_CS; i++)
      hit[i] = ((ADDR_IN ^ REGION_BASE[i*ADDR_W +: ADDR_W])
               & REGION_MASK[i*ADDR_W +: ADDR_W]) == '0;
    for (int i = NUM_CS - 1; i >= 0; i--)
      if (hit[i]) begin
        win = '0;
        win[i] = 1'b1;
      end
    for (int i = 0; i < NUM_CS; i++)
      if (win[i])
        win_wait = win_wait | REGION_WAIT[i*4 +: 4];
  end

  assign any_hit = |hit;
  assign win_ro = |(win & REGION_RO);
  assign ack_now = ext ? EXTACK_IN : (wcnt == 4'd0);
  assign wd_nxt = wd + 8'd1;
  assign rst_last = CPU_RESET
                  && (rst_cnt == 8'(RESET_CYCLES - 1));
  assign halt_clr = !CPU_HALT || rst_last;
  assign step_pulse = step_sync[1] & ~step_sync[2];

  // Step button synchroniser plus edge-detect history
  always_ff @(posedge CPUCLK_IN or negedge RESET_n) begin
    if (!RESET_n)
      step_sync <= '0;
    else
      step_sync <= {step_sync[1:0], STEP_IN};
  end

  // CPU power-on RESET/HALT pulse, restarted by every reset
  always_ff @(posedge CPUCLK_IN or negedge RESET_n) begin
    if (!RESET_n) begin
      rst_cnt <= '0;
      CPU_RESET <= 1'b1;
      CPU_HALT <= 1'b1;
    end else if (CPU_RESET) begin
      if (rst_last) begin
        CPU_RESET <= 1'b0;
        CPU_HALT <= 1'b0;
      end else begin
        rst_cnt <= rst_cnt + 8'd1;
      end
    end
  end

  // Bus-cycle state machine with registered strobes
  always_ff @(posedge CPUCLK_IN or negedge RESET_n) begin
    if (!RESET_n) begin
      state <= S_IDLE;
      sel <= '0;
      wcnt <= '0;
      ext <= 1'b0;
      wd <= '0;
      RUN <= 1'b0;
      DTACK <= 1'b0;
      BERR <= 1'b0;
      CSU <= '0;
      CSL <= '0;
      OE <= 1'b0;
      WE <= 1'b0;
    end else begin
      RUN <= halt_clr;
      if (state != S_IDLE && !AS_IN) begin
        state <= S_IDLE;
        DTACK <= 1'b0;
        BERR <= 1'b0;
        CSU <= '0;
        CSL <= '0;
        OE <= 1'b0;
        WE <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (AS_IN && !CPU_RESET) begin
              sel <= win;
              wcnt <= win_wait;
              ext <= (win_wait == 4'hF);
              wd <= '0;
              if (!any_hit || (WR_IN && win_ro)) begin
                state <= S_ERR;
                BERR <= 1'b1;
              end else begin
                state <= S_ACCESS;
                CSU <= UDS_IN ? win : '0;
                CSL <= LDS_IN ? win : '0;
                OE <= ~WR_IN;
                WE <= WR_IN;
              end
            end
          end
          S_ACCESS: begin
            CSU <= UDS_IN ? sel : '0;
            CSL <= LDS_IN ? sel : '0;
            if (ack_now) begin
              if (STEPEN_IN) begin
                state <= S_STEP;
                RUN <= 1'b0;
              end else begin
                state <= S_ACK;
                DTACK <= 1'b1;
              end
            end else if (ext
                && wd_nxt == 8'(BERR_TIMEOUT)) begin
              state <= S_ERR;
              BERR <= 1'b1;
              CSU <= '0;
              CSL <= '0;
              OE <= 1'b0;
              WE <= 1'b0;
            end else if (ext) begin
              wd <= wd_nxt;
            end else begin
              wcnt <= wcnt - 4'd1;
            end
          end
          S_STEP: begin
            CSU <= UDS_IN ? sel : '0;
            CSL <= LDS_IN ? sel : '0;
            if (step_pulse) begin
              state <= S_ACK;
              DTACK <= 1'b1;
            end else begin
              RUN <= 1'b0;
            end
          end
          S_ACK: begin
            CSU <= UDS_IN ? sel : '0;
            CSL <= LDS_IN ? sel : '0;
          end
          S_ERR: begin
            BERR <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

Parametrised 68000 bus-cycle controller replacing the fixed two-PROM/two-SRAM decoder. It decodes the CPU address into NUM_CS programmable regions and drives byte-lane chip selects, OE and WE. It inserts per-region wait states or waits on an external acknowledge, and generates DTACK or BERR, with a bus-error watchdog. It also owns the CPU power-on RESET/HALT pulse and single-step gating. It sits between the CPU bus pins (active-high after top-level inversion) and the memory/peripheral chip selects, clocked by the divided CPU clock.

## Interface
Parameters:
- NUM_CS, 4: number of decoded regions.
- ADDR_W, 24: address width.
- REGION_BASE, 0: NUM_CS*ADDR_W packed. Region i occupies slice [i*ADDR_W +: ADDR_W].
- REGION_MASK, 0: NUM_CS*ADDR_W packed. Bit set means the address bit is compared.
- REGION_WAIT, 0: NUM_CS*4 packed wait states. 4'hF selects external acknowledge.
- REGION_RO, 0: NUM_CS bits. Set means writes to the region cause BERR.
- BERR_TIMEOUT, 64: cycles before BERR in external-acknowledge mode (range 2..255).
- RESET_CYCLES, 16: CPU reset pulse length in cycles (range 1..255).

Ports:
- CPUCLK_IN  in  1  CPU clock; all logic on rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- AS_IN, WR_IN, UDS_IN, LDS_IN  in  1 each  CPU strobes, active high.
- ADDR_IN  in  ADDR_W  CPU address.
- EXTACK_IN  in  1  external acknowledge, level, synchronous.
- STEPEN_IN  in  1  single-step enable, level.
- STEP_IN  in  1  step button, asynchronous.
- CPU_RESET, CPU_HALT  out  1 each  CPU reset/halt drive, active high.
- RUN  out  1  CPU running indicator.
- DTACK, BERR  out  1 each  bus acknowledge / bus error.
- CSU, CSL  out  NUM_CS each  upper/lower byte-lane chip selects.
- OE, WE  out  1 each  read/write strobes.

## Operation
- Reset values: CPU_RESET=1, CPU_HALT=1, RUN=0, DTACK=0, BERR=0, CSU=CSL=0, OE=WE=0. The state machine is in IDLE.
- Reset pulse: a counter starts at RESET_n release. CPU_RESET and CPU_HALT stay at 1 for exactly RESET_CYCLES rising edges, then drop together.
- RUN is 1 when CPU_HALT=0 and the state is not STEP.
- Region hit i means ((ADDR_IN ^ BASE_i) & MASK_i) == 0. When several regions hit, the lowest index wins.
- STEP_IN passes through a 2-flop synchroniser and a rising-edge detector, producing a one-cycle step pulse.
- The state machine does not leave IDLE while CPU_RESET=1.
- IDLE: at the first edge with AS_IN=1, latch the winning region and its wait value into a counter.
  - No hit, or WR_IN=1 to a region with RO set: go to ERR.
  - Otherwise go to ACCESS. CSU[i]=UDS_IN, CSL[i]=LDS_IN, OE=~WR_IN, WE=WR_IN.
- ACCESS, counted mode (wait != F): each edge with counter > 0 decrements the counter. An edge with counter == 0 goes to STEP if STEPEN_IN=1, otherwise asserts DTACK and goes to ACK.
- ACCESS, external mode (wait == F): an edge with EXTACK_IN=1 takes the same exit as counter == 0. A watchdog counts edges in ACCESS. When it reaches BERR_TIMEOUT, drop the chip selects and go to ERR.
- STEP: hold the selects. A step pulse asserts DTACK and goes to ACK. The watchdog is frozen in this state.
- ACK: hold DTACK and the selects.
- ERR: BERR=1, chip selects 0.
- From any non-IDLE state, an edge with AS_IN=0 returns to IDLE. DTACK, BERR, CS, OE and WE clear on that same edge.
- Strobes are re-evaluated every cycle while selects are held, so the CS lanes track UDS_IN/LDS_IN.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- AS sampled high at edge E0: CS/OE/WE are valid after E0. With wait N, DTACK is valid after edge E0+N+1. N=0 gives DTACK one cycle after the chip select.
- External mode: DTACK follows the first edge that samples EXTACK_IN=1.
- Timeout: BERR is asserted after edge E0+BERR_TIMEOUT if no acknowledge arrives.
- AS_IN falls on the same edge that the counter expires or EXTACK_IN arrives: go to IDLE, DTACK is never asserted.
- A step pulse outside the STEP state is discarded, not queued.
- STEPEN_IN changing during ACCESS is sampled only at the exit decision.
- Asynchronous reset mid-cycle: all outputs go to reset values immediately, and the reset pulse restarts from zero at release.

## Test plan
- Reset, RESET_CYCLES=16: CPU_RESET and CPU_HALT are 1 for 16 edges after release, then 0. RUN rises on the same edge; DTACK, BERR, CSU and CSL stay 0 throughout.
- Region 0 (base 0x000000, mask 0xF00000), wait 2, read with UDS=LDS=1 at E0: CSU[0]=CSL[0]=OE=1 after E0, DTACK=1 after E3. AS low clears all outputs at the next edge.
- Write to 0x000010 with REGION_RO[0]=1: BERR=1 after E0, CSU=CSL=0 throughout. BERR clears when AS is sampled low.
- External region, EXTACK_IN held 0, BERR_TIMEOUT=64: BERR after E0+64. A repeat run with EXTACK_IN=1 at E0+5 gives DTACK after E0+5.
- STEPEN=1, wait 0: the cycle parks in STEP with RUN=0 and no DTACK for 100 cycles. A STEP_IN press gives DTACK about 3-4 cycles later; exactly one DTACK per press.
- Unmapped address 0x800000: BERR after E0. AS dropping on the counter-expiry edge of a wait-1 access produces no DTACK pulse.
